// File: rtl/mem_write_checker.sv
// Store-sequence checker: watches processor stores and compares them in order against a table
// of expected (address, data) pairs. Optional RUN timeout is enabled with CHECK_TIMEOUT_EN.
//
// state | meaning
// IDLE  | table may be loaded, waiting for start
// RUN   | comparing stores against table[match_cnt]
// PASS  | every table entry was matched in order (sticky)
// FAIL  | unexpected store or timeout seen (sticky)
module mem_write_checker #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4,
  parameter int SCRATCH_ADDR = 96,
  parameter int TIMEOUT      = 1000,
  parameter int CNT_W        = 16,
  localparam int IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] data_adr,
  input  logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [IDX_W:0]    match_cnt,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int TBL_N = 1 << IDX_W;
  localparam logic [IDX_W:0]    DEPTH_V = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]    LAST_M  = (IDX_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] SCR_A   = ADDR_W'(SCRATCH_ADDR);
  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_STORE   = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;

  if (DEPTH < 1 || DEPTH > 16 || TIMEOUT < 1) begin : g_bad_param
    $error("mem_write_checker: DEPTH must be 1..16 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
  state_t state;

  // Table is deliberately not reset so a run can be repeated after reset without reloading.
  logic [ADDR_W-1:0] tbl_addr [TBL_N];
  logic [DATA_W-1:0] tbl_data [TBL_N];

  logic idx_ok, hit, scratch, bad, last_hit, timed_out;

  always_comb begin
    idx_ok   = ({1'b0, cfg_idx} < DEPTH_V);
    hit      = mem_write && (data_adr == tbl_addr[match_cnt[IDX_W-1:0]])
                         && (write_data == tbl_data[match_cnt[IDX_W-1:0]]);
    scratch  = mem_write && !hit && (data_adr == SCR_A);
    bad      = mem_write && !hit && !scratch;
    last_hit = hit && (match_cnt == LAST_M);
`ifdef CHECK_TIMEOUT_EN
    timed_out = (cycle_cnt == CNT_W'(TIMEOUT - 1));
`else
    timed_out = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && cfg_we && idx_ok) begin
      tbl_addr[cfg_idx] <= cfg_addr;
      tbl_data[cfg_idx] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fail_code <= FC_NONE;
      fail_addr <= '0;
      fail_data <= '0;
      match_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
          if (hit) match_cnt <= match_cnt + 1'b1;
          // A store outcome on the same edge wins over the timeout.
          if (last_hit) begin
            state <= PASS;
          end else if (bad) begin
            state     <= FAIL;
            fail_code <= FC_STORE;
            fail_addr <= data_adr;
            fail_data <= write_data;
          end else if (timed_out) begin
            state     <= FAIL;
            fail_code <= FC_TIMEOUT;
          end
        end
        default: begin
          if (start) begin
            state     <= RUN;
            fail_code <= FC_NONE;
            fail_addr <= '0;
            fail_data <= '0;
            match_cnt <= '0;
            cycle_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == PASS) || (state == FAIL);
  assign pass = (state == PASS);
  assign fail = (state == FAIL);

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: a DEPTH=1 and a DEPTH=3 (TIMEOUT=20) instance
// share stimulus; each scenario checks the instance it targets.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset, start, cfg_we1, cfg_we3, mem_write;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data, data_adr, write_data;

  logic        d1_busy, d1_done, d1_pass, d1_fail;
  logic [1:0]  d1_code;
  logic [31:0] d1_faddr, d1_fdata;
  logic [1:0]  d1_match;
  logic [15:0] d1_cyc;

  logic        d3_busy, d3_done, d3_pass, d3_fail;
  logic [1:0]  d3_code;
  logic [31:0] d3_faddr, d3_fdata;
  logic [2:0]  d3_match;
  logic [15:0] d3_cyc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.DEPTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we1), .cfg_idx(cfg_idx[0]),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .busy(d1_busy), .done(d1_done), .pass(d1_pass), .fail(d1_fail),
    .fail_code(d1_code), .fail_addr(d1_faddr), .fail_data(d1_fdata), .match_cnt(d1_match),
    .cycle_cnt(d1_cyc)
  );

  mem_write_checker #(.DEPTH(3), .TIMEOUT(20)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we3), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .busy(d3_busy), .done(d3_done), .pass(d3_pass), .fail(d3_fail),
    .fail_code(d3_code), .fail_addr(d3_faddr), .fail_data(d3_fdata), .match_cnt(d3_match),
    .cycle_cnt(d3_cyc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input bit to3, input int idx, input int a, input int d);
    cfg_idx  = 2'(idx);
    cfg_addr = 32'(a);
    cfg_data = 32'(d);
    cfg_we1  = !to3;
    cfg_we3  = to3;
    step();
    cfg_we1 = 1'b0;
    cfg_we3 = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic store(input int a, input int d);
    data_adr   = 32'(a);
    write_data = 32'(d);
    mem_write  = 1'b1;
    step();
    mem_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_we1 = 1'b0; cfg_we3 = 1'b0; mem_write = 1'b0;
    cfg_idx = '0; cfg_addr = '0; cfg_data = '0; data_adr = '0; write_data = '0;
    #1;
    step(); step();
    reset = 1'b0;
    chk("rst_busy", d3_busy, 0);
    chk("rst_done", d3_done, 0);
    chk("rst_pass", d3_pass, 0);
    chk("rst_fail", d3_fail, 0);
    chk("rst_code", d3_code, 0);
    chk("rst_faddr", d3_faddr, 0);
    chk("rst_match", d3_match, 0);
    chk("rst_cyc", d3_cyc, 0);
    chk("rst_d1_busy", d1_busy, 0);

    cfg(0, 0, 100, 25);
    cfg(1, 0, 100, 1);
    cfg(1, 1, 104, 2);
    cfg(1, 2, 108, 3);

    // DEPTH=1: scratch store ignored, then the expected store passes
    go();
    chk("d1_start_busy", d1_busy, 1);
    chk("d1_start_cyc", d1_cyc, 0);
    store(96, 7);
    chk("d1_scr_busy", d1_busy, 1);
    chk("d1_scr_match", d1_match, 0);
    store(100, 25);
    chk("d1_pass", d1_pass, 1);
    chk("d1_pass_match", d1_match, 1);
    chk("d1_pass_fail", d1_fail, 0);
    chk("d1_pass_done", d1_done, 1);
    chk("d1_pass_busy", d1_busy, 0);
    chk("d1_pass_cyc", d1_cyc, 2);
    store(104, 25);
    chk("d1_pass_sticky", d1_pass, 1);

    // restart from PASS, table write during RUN must be ignored
    go();
    chk("d1_rs_busy", d1_busy, 1);
    chk("d1_rs_match", d1_match, 0);
    chk("d1_rs_cyc", d1_cyc, 0);
    cfg(0, 0, 200, 9);
    store(104, 25);
    chk("d1_bad_fail", d1_fail, 1);
    chk("d1_bad_code", d1_code, 1);
    chk("d1_bad_faddr", d1_faddr, 104);
    chk("d1_bad_fdata", d1_fdata, 25);
    chk("d1_bad_match", d1_match, 0);
    store(100, 25);
    chk("d1_fail_sticky", d1_fail, 1);
    chk("d1_fail_faddr_hold", d1_faddr, 104);
    go();
    store(100, 25);
    chk("d1_tbl_kept_pass", d1_pass, 1);
    chk("d1_clr_code", d1_code, 0);
    chk("d1_clr_faddr", d1_faddr, 0);

    // DEPTH=3: out-of-order store fails, in-order with scratch passes
    go();
    store(104, 2);
    chk("d3_ooo_fail", d3_fail, 1);
    chk("d3_ooo_code", d3_code, 1);
    chk("d3_ooo_match", d3_match, 0);
    chk("d3_ooo_faddr", d3_faddr, 104);
    chk("d3_ooo_fdata", d3_fdata, 2);
    go();
    store(100, 1);
    chk("d3_m1", d3_match, 1);
    chk("d3_m1_busy", d3_busy, 1);
    store(96, 0);
    chk("d3_scr_match", d3_match, 1);
    chk("d3_scr_busy", d3_busy, 1);
    store(104, 2);
    store(108, 3);
    chk("d3_pass", d3_pass, 1);
    chk("d3_pass_match", d3_match, 3);
    chk("d3_pass_cyc", d3_cyc, 4);

    // reset mid-run aborts; table survives
    go();
    store(100, 1);
    chk("d3_mid_match", d3_match, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_busy", d3_busy, 0);
    chk("mr_done", d3_done, 0);
    chk("mr_pass", d3_pass, 0);
    chk("mr_fail", d3_fail, 0);
    chk("mr_match", d3_match, 0);
    chk("mr_cyc", d3_cyc, 0);
    go();
    store(100, 1);
    store(104, 2);
    store(108, 3);
    chk("mr_rerun_pass", d3_pass, 1);
    chk("mr_rerun_match", d3_match, 3);

`ifdef CHECK_TIMEOUT_EN
    go();
    repeat (19) step();
    chk("to_pre_busy", d3_busy, 1);
    chk("to_pre_cyc", d3_cyc, 19);
    step();
    chk("to_fail", d3_fail, 1);
    chk("to_code", d3_code, 2);
    chk("to_faddr", d3_faddr, 0);
    chk("to_fdata", d3_fdata, 0);
    chk("to_cyc", d3_cyc, 20);
    go();
    store(100, 1);
    store(104, 2);
    repeat (17) step();
    chk("to_race_busy", d3_busy, 1);
    chk("to_race_cyc", d3_cyc, 19);
    store(108, 3);
    chk("to_race_pass", d3_pass, 1);
    chk("to_race_fail", d3_fail, 0);
    chk("to_race_cyc20", d3_cyc, 20);
`else
    go();
    repeat (30) step();
    chk("noto_busy", d3_busy, 1);
    chk("noto_fail", d3_fail, 0);
    chk("noto_cyc", d3_cyc, 30);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter ADDR_W, default 32, width of the monitored store address.
REQ-002 Parameter DATA_W, default 32, width of the monitored store data.
REQ-003 Parameter DEPTH, default 4, legal 1..16, number of expected-write table entries; IDX_W = max(1, clog2(DEPTH)).
REQ-004 Parameter SCRATCH_ADDR, default 96, address whose stores are tolerated and ignored.
REQ-005 Parameter TIMEOUT, default 1000, RUN-cycle limit, used only with the Configuration macro.
REQ-006 Parameter CNT_W, default 16, width of cycle_cnt.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  begin a check run.
REQ-010 cfg_we  in  1  table write strobe.
REQ-011 cfg_idx  in  IDX_W  table entry index.
REQ-012 cfg_addr  in  ADDR_W  expected store address.
REQ-013 cfg_data  in  DATA_W  expected store data.
REQ-014 mem_write  in  1  processor store strobe.
REQ-015 data_adr  in  ADDR_W  processor store address.
REQ-016 write_data  in  DATA_W  processor store data.
REQ-017 busy  out  1  state is RUN.
REQ-018 done  out  1  state is PASS or FAIL.
REQ-019 pass  out  1  state is PASS.
REQ-020 fail  out  1  state is FAIL.
REQ-021 fail_code  out  2  0 none, 1 unexpected store, 2 timeout, 3 reserved and never driven.
REQ-022 fail_addr  out  ADDR_W  address of the offending store.
REQ-023 fail_data  out  DATA_W  data of the offending store.
REQ-024 match_cnt  out  IDX_W+1  number of expected stores matched so far.
REQ-025 cycle_cnt  out  CNT_W  number of RUN cycles elapsed.

Function
REQ-026 States SHALL be IDLE, RUN, PASS and FAIL; all outputs SHALL be registered or decoded directly from registers.
REQ-027 In IDLE, cfg_we=1 with cfg_idx<DEPTH SHALL write {cfg_addr,cfg_data} into the table; cfg_we SHALL be ignored in any other state or when cfg_idx>=DEPTH.
REQ-028 start=1 in IDLE, PASS or FAIL SHALL enter RUN on the next edge and clear match_cnt, cycle_cnt, fail_code, fail_addr and fail_data; start SHALL be ignored in RUN.
REQ-029 In RUN, cycle_cnt SHALL increment every cycle and saturate at all-ones.
REQ-030 In RUN with mem_write=1, a store matching table[match_cnt] in both address and data SHALL increment match_cnt; if this is entry DEPTH-1, the state SHALL go to PASS on the same edge.
REQ-031 Otherwise, a store with data_adr==SCRATCH_ADDR SHALL be ignored.
REQ-032 Any other store SHALL go to FAIL with fail_code=1 and capture data_adr and write_data into fail_addr and fail_data.
REQ-033 Priority SHALL be: expected match, then scratch, then fail.
REQ-034 Latency: a store sampled at edge k SHALL be reflected on pass, fail and match_cnt immediately after edge k.
REQ-035 PASS and FAIL SHALL be sticky, holding all outputs until reset or start; mem_write SHALL be ignored outside RUN.

Reset
REQ-036 reset SHALL take priority over all other inputs and force IDLE on the next edge.
REQ-037 After reset: busy, done, pass and fail SHALL be 0; fail_code, fail_addr, fail_data, match_cnt and cycle_cnt SHALL be 0.
REQ-038 Table contents SHALL be retained through reset; reset during RUN SHALL abort the run without reporting a result.

Configuration
REQ-039 With CHECK_TIMEOUT_EN defined, a RUN cycle with cycle_cnt==TIMEOUT-1 that does not complete or fail on a store SHALL go to FAIL with fail_code=2; fail_addr and fail_data SHALL remain 0.
REQ-040 When a store result and the timeout occur on the same edge, the store result SHALL take precedence.
REQ-041 Without CHECK_TIMEOUT_EN, no timeout logic SHALL exist, fail_code SHALL never be 2, and RUN SHALL last indefinitely.

Verification
REQ-042 DEPTH=1, table[0]=(100,25); start; stores (96,7) then (100,25) -> pass=1, match_cnt=1, fail=0.
REQ-043 Same table; store (104,25) -> fail=1, fail_code=1, fail_addr=104, fail_data=25.
REQ-044 DEPTH=3, table (100,1),(104,2),(108,3); stores (104,2) first -> fail_code=1, match_cnt=0; in-order stores -> pass, match_cnt=3.
REQ-045 CHECK_TIMEOUT_EN, TIMEOUT=20, no stores after start -> fail_code=2 after exactly 20 RUN cycles; also a matching final store on cycle 20 -> pass.
REQ-046 reset asserted mid-RUN after 1 match -> IDLE and all outputs 0; new start with no table reload -> run passes with the retained table.
REQ-047 start asserted in PASS -> RUN with match_cnt=0 and cycle_cnt=0; cfg_we asserted in RUN -> table unchanged.
